mode2_demux: RTL and testbench

MODE2_DEMUX -- requirements
Module: mode2_demux

---
 rtl/mode2_demux_if.sv | 24 ++
 rtl/mode2_demux.sv | 118 +++++++++++
 tb/tb_mode2_demux.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/mode2_demux_if.sv
// Bundles the mode-2 demux control inputs, the multiplexed stream and the split outputs.
interface mode2_demux_if #(parameter int unsigned DATA_W = 16);
   logic              enable;
   logic              align;
   logic [31:0]       switch_clk_cycles;
   logic [DATA_W-1:0] mux_in;
   logic [DATA_W-1:0] ds1_out;
   logic [DATA_W-1:0] ds2_out;
   logic              ds1_valid;
   logic              ds2_valid;
   logic              frame_start;
   logic              locked;
   logic              cfg_err;

   modport slave (
      input  enable, align, switch_clk_cycles, mux_in,
      output ds1_out, ds2_out, ds1_valid, ds2_valid, frame_start, locked, cfg_err
   );

   modport master (
      output enable, align, switch_clk_cycles, mux_in,
      input  ds1_out, ds2_out, ds1_valid, ds2_valid, frame_start, locked, cfg_err
   );
endinterface

// File: rtl/mode2_demux.sv
// Splits a time-multiplexed stream into DS1/DS2 using N-cycle windows; align marks DS1 sample 1.
module mode2_demux #(
   parameter int unsigned DATA_W = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   mode2_demux_if.slave  bus
);
   localparam int unsigned CNT_W = 32;
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   logic [0:0]        r_state;
   logic [CNT_W-1:0]  r_k;
   logic [CNT_W-1:0]  r_nl;
   logic [DATA_W-1:0] r_ds1;
   logic [DATA_W-1:0] r_ds2;
   logic              r_ds1_valid;
   logic              r_ds2_valid;
   logic              r_frame_start;
   logic              r_cfg_err;

   logic [0:0]        w_state_nxt;
   logic [CNT_W-1:0]  w_k_nxt;
   logic [CNT_W-1:0]  w_nl_nxt;
   logic [DATA_W-1:0] w_ds1_nxt;
   logic [DATA_W-1:0] w_ds2_nxt;
   logic              w_ds1_valid_nxt;
   logic              w_ds2_valid_nxt;
   logic              w_frame_start_nxt;
   logic              w_cfg_err_nxt;
   logic              w_n_zero;
   logic              w_frame_end;

   assign w_n_zero    = (bus.switch_clk_cycles == '0);
   // Widened compare so 2*NL cannot wrap for large window lengths.
   assign w_frame_end = ({1'b0, r_k} == {r_nl, 1'b0});

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= ST_IDLE;
         r_k           <= CNT_W'(1);
         r_nl          <= '0;
         r_ds1         <= '0;
         r_ds2         <= '0;
         r_ds1_valid   <= 1'b0;
         r_ds2_valid   <= 1'b0;
         r_frame_start <= 1'b0;
         r_cfg_err     <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_k           <= w_k_nxt;
         r_nl          <= w_nl_nxt;
         r_ds1         <= w_ds1_nxt;
         r_ds2         <= w_ds2_nxt;
         r_ds1_valid   <= w_ds1_valid_nxt;
         r_ds2_valid   <= w_ds2_valid_nxt;
         r_frame_start <= w_frame_start_nxt;
         r_cfg_err     <= w_cfg_err_nxt;
      end
   end

   // Next state: align (re)starts a frame from any state; otherwise RUN walks k through 1..2NL.
   always_comb begin
      w_state_nxt       = r_state;
      w_k_nxt           = r_k;
      w_nl_nxt          = r_nl;
      w_ds1_nxt         = r_ds1;
      w_ds2_nxt         = r_ds2;
      w_ds1_valid_nxt   = 1'b0;
      w_ds2_valid_nxt   = 1'b0;
      w_frame_start_nxt = 1'b0;
      w_cfg_err_nxt     = r_cfg_err;

      if (!bus.enable) begin
         w_state_nxt = ST_IDLE;
      end else if (bus.align) begin
         if (w_n_zero) begin
            w_state_nxt   = ST_IDLE;
            w_cfg_err_nxt = 1'b1;
         end else begin
            w_state_nxt       = ST_RUN;
            w_nl_nxt          = bus.switch_clk_cycles;
            w_k_nxt           = CNT_W'(2);
            w_ds1_nxt         = bus.mux_in;
            w_ds1_valid_nxt   = 1'b1;
            w_frame_start_nxt = 1'b1;
         end
      end else if (r_state == ST_RUN) begin
         if (r_k <= r_nl) begin
            w_ds1_nxt       = bus.mux_in;
            w_ds1_valid_nxt = 1'b1;
         end else begin
            w_ds2_nxt       = bus.mux_in;
            w_ds2_valid_nxt = 1'b1;
         end
         w_frame_start_nxt = (r_k == CNT_W'(1));
         if (w_frame_end) begin
            w_k_nxt  = CNT_W'(1);
            w_nl_nxt = bus.switch_clk_cycles;
            if (w_n_zero) begin
               w_state_nxt   = ST_IDLE;
               w_cfg_err_nxt = 1'b1;
            end
         end else begin
            w_k_nxt = r_k + CNT_W'(1);
         end
      end
   end

   assign bus.ds1_out     = r_ds1;
   assign bus.ds2_out     = r_ds2;
   assign bus.ds1_valid   = r_ds1_valid;
   assign bus.ds2_valid   = r_ds2_valid;
   assign bus.frame_start = r_frame_start;
   assign bus.locked      = (r_state == ST_RUN);
   assign bus.cfg_err     = r_cfg_err;
endmodule

// File: tb/tb_mode2_demux.sv
// Table-driven bench for mode2_demux: each vector's expected outputs go through a scoreboard queue.
module tb_mode2_demux;
   localparam int unsigned DATA_W = 16;

   typedef struct packed {
      logic              d1v;
      logic              d2v;
      logic              fs;
      logic              lk;
      logic              err;
      logic [DATA_W-1:0] d1;
      logic [DATA_W-1:0] d2;
   } exp_t;

   typedef struct {
      logic              en;
      logic              al;
      logic [31:0]       n;
      logic [DATA_W-1:0] din;
      exp_t              exp;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   failures = 0;
   vec_t vecs[$];
   exp_t sb_q[$];

   mode2_demux_if #(.DATA_W(DATA_W)) bus ();

   mode2_demux #(.DATA_W(DATA_W)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input logic en, input logic al, input int n, input int din,
                               input logic d1v, input logic d2v, input int d1, input int d2,
                               input logic fs, input logic lk, input logic err);
      vec_t v;
      v.en      = en;
      v.al      = al;
      v.n       = 32'(n);
      v.din     = DATA_W'(din);
      v.exp.d1v = d1v;
      v.exp.d2v = d2v;
      v.exp.fs  = fs;
      v.exp.lk  = lk;
      v.exp.err = err;
      v.exp.d1  = DATA_W'(d1);
      v.exp.d2  = DATA_W'(d2);
      return v;
   endfunction

   function automatic exp_t sample();
      exp_t s;
      s.d1v = bus.ds1_valid;
      s.d2v = bus.ds2_valid;
      s.fs  = bus.frame_start;
      s.lk  = bus.locked;
      s.err = bus.cfg_err;
      s.d1  = bus.ds1_out;
      s.d2  = bus.ds2_out;
      return s;
   endfunction

   task automatic check(input string name, input exp_t act, input exp_t exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got d1v=%b d2v=%b fs=%b lk=%b err=%b d1=%h d2=%h, want d1v=%b d2v=%b fs=%b lk=%b err=%b d1=%h d2=%h",
                  name, act.d1v, act.d2v, act.fs, act.lk, act.err, act.d1, act.d2,
                  exp.d1v, exp.d2v, exp.fs, exp.lk, exp.err, exp.d1, exp.d2);
      end
   endtask

   // Drive each vector, queue its expectation, pop and compare once the edge has produced output.
   task automatic run_seg(input string name);
      exp_t exp;
      for (int i = 0; i < vecs.size(); i++) begin
         bus.enable            = vecs[i].en;
         bus.align             = vecs[i].al;
         bus.switch_clk_cycles = vecs[i].n;
         bus.mux_in            = vecs[i].din;
         sb_q.push_back(vecs[i].exp);
         @(posedge clk);
         #1;
         if (sb_q.size() == 0) begin
            failures++;
            checks++;
            $display("FAIL %s[%0d]: scoreboard empty", name, i);
         end else begin
            exp = sb_q.pop_front();
            check($sformatf("%s[%0d]", name, i), sample(), exp);
         end
      end
      vecs.delete();
   endtask

   task automatic pulse_reset(input string name);
      #1 rst_n = 1'b0;
      #1 check(name, sample(), '0);
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      rst_n                 = 1'b0;
      bus.enable            = 1'b0;
      bus.align             = 1'b0;
      bus.switch_clk_cycles = '0;
      bus.mux_in            = '0;
      @(posedge clk);
      @(posedge clk);
      #1 check("reset", sample(), '0);
      rst_n = 1'b1;

      // N=3, A..G: three DS1, three DS2, then G starts a new frame
      vecs.push_back(mk(1,1,3,'hA0, 1,0,'hA0,0,     1,1,0));
      vecs.push_back(mk(1,0,3,'hA1, 1,0,'hA1,0,     0,1,0));
      vecs.push_back(mk(1,0,3,'hA2, 1,0,'hA2,0,     0,1,0));
      vecs.push_back(mk(1,0,3,'hA3, 0,1,'hA2,'hA3,  0,1,0));
      vecs.push_back(mk(1,0,3,'hA4, 0,1,'hA2,'hA4,  0,1,0));
      vecs.push_back(mk(1,0,3,'hA5, 0,1,'hA2,'hA5,  0,1,0));
      vecs.push_back(mk(1,0,3,'hA6, 1,0,'hA6,'hA5,  1,1,0));
      vecs.push_back(mk(0,0,3,'hA7, 0,0,'hA6,'hA5,  0,0,0));
      vecs.push_back(mk(1,0,3,'hA8, 0,0,'hA6,'hA5,  0,0,0));
      run_seg("n3_frame");

      // N=1: DS1/DS2 alternate every cycle
      vecs.push_back(mk(1,1,1,1, 1,0,1,'hA5, 1,1,0));
      vecs.push_back(mk(1,0,1,2, 0,1,1,2,    0,1,0));
      vecs.push_back(mk(1,0,1,3, 1,0,3,2,    1,1,0));
      vecs.push_back(mk(1,0,1,4, 0,1,3,4,    0,1,0));
      vecs.push_back(mk(0,0,1,5, 0,0,3,4,    0,0,0));
      run_seg("n1_alt");

      // N=4, changed to 2 at k=3: this frame 4+4, next 2+2
      vecs.push_back(mk(1,1,4,'h10, 1,0,'h10,4,     1,1,0));
      vecs.push_back(mk(1,0,4,'h11, 1,0,'h11,4,     0,1,0));
      vecs.push_back(mk(1,0,2,'h12, 1,0,'h12,4,     0,1,0));
      vecs.push_back(mk(1,0,2,'h13, 1,0,'h13,4,     0,1,0));
      vecs.push_back(mk(1,0,2,'h14, 0,1,'h13,'h14,  0,1,0));
      vecs.push_back(mk(1,0,2,'h15, 0,1,'h13,'h15,  0,1,0));
      vecs.push_back(mk(1,0,2,'h16, 0,1,'h13,'h16,  0,1,0));
      vecs.push_back(mk(1,0,2,'h17, 0,1,'h13,'h17,  0,1,0));
      vecs.push_back(mk(1,0,2,'h18, 1,0,'h18,'h17,  1,1,0));
      vecs.push_back(mk(1,0,2,'h19, 1,0,'h19,'h17,  0,1,0));
      vecs.push_back(mk(1,0,2,'h1A, 0,1,'h19,'h1A,  0,1,0));
      vecs.push_back(mk(1,0,2,'h1B, 0,1,'h19,'h1B,  0,1,0));
      vecs.push_back(mk(1,0,2,'h1C, 1,0,'h1C,'h1B,  1,1,0));
      run_seg("n_change");

      // N=3 with a second align at k=5: restart as DS1 sample 1
      vecs.push_back(mk(1,1,3,'h20, 1,0,'h20,'h1B,  1,1,0));
      vecs.push_back(mk(1,0,3,'h21, 1,0,'h21,'h1B,  0,1,0));
      vecs.push_back(mk(1,0,3,'h22, 1,0,'h22,'h1B,  0,1,0));
      vecs.push_back(mk(1,0,3,'h23, 0,1,'h22,'h23,  0,1,0));
      vecs.push_back(mk(1,1,3,'h24, 1,0,'h24,'h23,  1,1,0));
      vecs.push_back(mk(1,0,3,'h25, 1,0,'h25,'h23,  0,1,0));
      vecs.push_back(mk(1,0,3,'h26, 1,0,'h26,'h23,  0,1,0));
      run_seg("resync");

      // Reset at k=4, then idle until align; N=0 at a frame boundary drops to IDLE with cfg_err
      pulse_reset("async_reset_mid");
      vecs.push_back(mk(1,0,3,'h50, 0,0,0,0,        0,0,0));
      vecs.push_back(mk(1,0,3,'h51, 0,0,0,0,        0,0,0));
      vecs.push_back(mk(1,1,2,'h52, 1,0,'h52,0,     1,1,0));
      vecs.push_back(mk(1,0,2,'h53, 1,0,'h53,0,     0,1,0));
      vecs.push_back(mk(1,0,0,'h54, 0,1,'h53,'h54,  0,1,0));
      vecs.push_back(mk(1,0,0,'h55, 0,1,'h53,'h55,  0,0,1));
      vecs.push_back(mk(1,0,0,'h56, 0,0,'h53,'h55,  0,0,1));
      run_seg("post_reset");

      // N=0 at align: no valids, cfg_err sticks through a later good frame
      pulse_reset("reset_clears_err");
      vecs.push_back(mk(1,1,0,'h60, 0,0,0,0,        0,0,1));
      vecs.push_back(mk(1,0,0,'h61, 0,0,0,0,        0,0,1));
      vecs.push_back(mk(1,1,2,'h62, 1,0,'h62,0,     1,1,1));
      vecs.push_back(mk(1,0,2,'h63, 1,0,'h63,0,     0,1,1));
      run_seg("n0_align");
      pulse_reset("final_reset");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
